alu4_sched: RTL and testbench
=============================

Name: alu4_sched

Overview:
- Shares one alu4 instance between NUM_REQ requesters using round-robin arbitration with valid/ready handshakes.
- Captures the winning operands into registers, executes one op, and returns a tagged, registered result on a single response channel.
- Sits between client blocks (sequencers, test drivers) and the 4-bit ALU datapath; instantiates alu4 internally.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester tag; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  one-hot accept pulse to the granted requester.
- req_op  input  2*NUM_REQ  per-requester op; slice i = [2i+1:2i]; encoding ADD=0, SUB=1, AND=2, OR=3.
- req_a  input  4*NUM_REQ  per-requester operand A, slice i = [4i+3:4i].
- req_b  input  4*NUM_REQ  per-requester operand B, same slicing.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  ID_W  index of the requester that owns the response.
- rsp_result  output  4  alu4 result.
- rsp_overflow  output  1  alu4 overflow flag: carry-out for ADD, borrow for SUB, 0 for AND/OR.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE; priority pointer = 0.
  - req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_result = 0, rsp_overflow = 0, busy = 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is high, grant the first asserted requester at or after the pointer, wrapping modulo NUM_REQ.
  - req_ready[grant] = 1 combinationally for that cycle only.
  - On that edge, capture op/a/b/id into internal registers, move to EXEC, and set pointer = grant+1, wrapping NUM_REQ-1 to 0.
  - If no request is valid, stay in IDLE; the pointer is unchanged.
- EXEC:
  - alu4 is driven from the captured registers.
  - On the edge, register result, overflow and id into the rsp_* registers, set rsp_valid = 1, and move to RESP.
- RESP:
  - Hold rsp_* stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_valid & rsp_ready, clear rsp_valid and return to IDLE.
  - rsp_result, rsp_overflow and rsp_id keep their last values after rsp_valid drops.
- Timing:
  - Latency from the accept edge to rsp_valid is 1 cycle.
  - Minimum issue interval is 3 cycles (IDLE, EXEC, RESP); no overlap between requests.
- req_ready is 0 in EXEC and RESP. Requests arriving then are held by the requester and are not lost.
- Requesters must hold req_valid, op, a and b stable until req_ready. Deasserting req_valid before acceptance is allowed in IDLE and causes no grant.
- Arithmetic: 4-bit results wrap modulo 16, e.g. 1111+0001 = 0000 with overflow=1.
- Reset mid-operation aborts any captured request. The in-flight response is dropped and not replayed.
- Requester indices >= NUM_REQ do not exist; the pointer never reaches them.

Optional Feature:
- Macro: ALU4_SCHED_STICKY_OVF_EN.
- With the macro defined:
  - Add output ovf_sticky [NUM_REQ] and input ovf_clr [NUM_REQ].
  - Bit i sets when a response for id i completes its handshake with rsp_overflow=1.
  - Bit i clears on ovf_clr[i]. When set and clear hit the same cycle, set wins.
  - All bits reset to 0.
- Without the macro: no extra ports and no sticky registers.

Test Plan:
- Single ADD: req 0 sends a=0100, b=0011, op=ADD; rsp_ready held 1 -> rsp_valid 2 cycles after req_valid, rsp_result=0111, rsp_overflow=0, rsp_id=0.
- Ops through different requesters:
  - req1 SUB 1010-0100 -> result 0110, overflow 0.
  - req2 AND 1010&1100 -> result 1000, overflow 0.
  - req3 OR 1010|1100 -> result 1110, overflow 0.
- Carry and borrow:
  - ADD 1111+0001 -> result 0000, overflow 1.
  - SUB 0000-0001 -> result 1111, overflow 1.
- Round-robin: all 4 requesters continuously valid after reset -> grant order 0,1,2,3,0; each req_ready is a single-cycle pulse; rsp_id follows the same order.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stay stable, req_ready stays 0, busy=1; the next grant happens in the cycle after rsp_ready=1.
- Async reset: assert rst_n=0 during EXEC -> rsp_valid, busy and req_ready go 0 immediately; after release, no response appears for the aborted request and the pointer is 0.

Source files
------------

// File: rtl/alu4_sched.sv
// Round-robin scheduler sharing one 4-bit ALU between NUM_REQ valid/ready requesters.
// Optional ALU4_SCHED_STICKY_OVF_EN adds per-requester sticky overflow flags.
module alu4 (
    input  logic [1:0] op,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] result,
    output logic       overflow
);
    logic [4:0] wide;

    always_comb begin
        wide     = 5'd0;
        result   = 4'd0;
        overflow = 1'b0;
        case (op)
            2'd0: begin
                wide     = {1'b0, a} + {1'b0, b};
                result   = wide[3:0];
                overflow = wide[4];
            end
            2'd1: begin
                // bit 4 of the widened difference is the borrow
                wide     = {1'b0, a} - {1'b0, b};
                result   = wide[3:0];
                overflow = wide[4];
            end
            2'd2: result = a & b;
            default: result = a | b;
        endcase
    end
endmodule

module alu4_sched #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [2*NUM_REQ-1:0] req_op,
    input  logic [4*NUM_REQ-1:0] req_a,
    input  logic [4*NUM_REQ-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [3:0]           rsp_result,
    output logic                 rsp_overflow,
`ifdef ALU4_SCHED_STICKY_OVF_EN
    output logic [NUM_REQ-1:0]   ovf_sticky,
    input  logic [NUM_REQ-1:0]   ovf_clr,
`endif
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state_reg, state_next;
    logic [ID_W-1:0] ptr_reg, ptr_next;
    logic [1:0]      op_reg;
    logic [3:0]      a_reg, b_reg;
    logic [ID_W-1:0] id_reg;
    logic            rsp_valid_reg;
    logic [ID_W-1:0] rsp_id_reg;
    logic [3:0]      rsp_result_reg;
    logic            rsp_overflow_reg;

    logic [1:0]      op_arr [NUM_REQ];
    logic [3:0]      a_arr  [NUM_REQ];
    logic [3:0]      b_arr  [NUM_REQ];
    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic            capture, load_rsp, rsp_done;
    logic [3:0]      alu_result;
    logic            alu_overflow;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign op_arr[gi] = req_op[2*gi +: 2];
            assign a_arr[gi]  = req_a[4*gi +: 4];
            assign b_arr[gi]  = req_b[4*gi +: 4];
        end
    endgenerate

    // First valid requester at or after the pointer, wrapping within NUM_REQ.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_reg) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        req_ready  = '0;
        capture    = 1'b0;
        load_rsp   = 1'b0;
        rsp_done   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant_found) begin
                    req_ready  = NUM_REQ'(1) << grant_idx;
                    capture    = 1'b1;
                    ptr_next   = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                load_rsp   = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_done   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    alu4 u_alu4 (
        .op       (op_reg),
        .a        (a_reg),
        .b        (b_reg),
        .result   (alu_result),
        .overflow (alu_overflow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            ptr_reg          <= '0;
            op_reg           <= '0;
            a_reg            <= '0;
            b_reg            <= '0;
            id_reg           <= '0;
            rsp_valid_reg    <= 1'b0;
            rsp_id_reg       <= '0;
            rsp_result_reg   <= '0;
            rsp_overflow_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            if (capture) begin
                op_reg <= op_arr[grant_idx];
                a_reg  <= a_arr[grant_idx];
                b_reg  <= b_arr[grant_idx];
                id_reg <= grant_idx;
            end
            if (load_rsp) begin
                rsp_valid_reg    <= 1'b1;
                rsp_id_reg       <= id_reg;
                rsp_result_reg   <= alu_result;
                rsp_overflow_reg <= alu_overflow;
            end else if (rsp_done) begin
                rsp_valid_reg <= 1'b0;
            end
        end
    end

`ifdef ALU4_SCHED_STICKY_OVF_EN
    logic [NUM_REQ-1:0] sticky_reg;

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_sticky
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sticky_reg[gi] <= 1'b0;
                end else if (rsp_done && rsp_overflow_reg && rsp_id_reg == ID_W'(gi)) begin
                    sticky_reg[gi] <= 1'b1;
                end else if (ovf_clr[gi]) begin
                    sticky_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign ovf_sticky = sticky_reg;
`endif

    assign rsp_valid    = rsp_valid_reg;
    assign rsp_id       = rsp_id_reg;
    assign rsp_result   = rsp_result_reg;
    assign rsp_overflow = rsp_overflow_reg;
    assign busy         = (state_reg != IDLE);
endmodule

// File: tb/tb_alu4_sched.sv
// Directed self-checking bench for alu4_sched: ops, carry/borrow, round-robin order,
// response backpressure and asynchronous reset abort.
module tb_alu4_sched;
    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [7:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_result;
    logic        rsp_overflow;
    logic        busy;
`ifdef ALU4_SCHED_STICKY_OVF_EN
    logic [3:0]  ovf_sticky;
    logic [3:0]  ovf_clr;
`endif

    int checks;
    int errors;

    alu4_sched #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result),
        .rsp_overflow (rsp_overflow),
`ifdef ALU4_SCHED_STICKY_OVF_EN
        .ovf_sticky   (ovf_sticky),
        .ovf_clr      (ovf_clr),
`endif
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        req_op[2*i +: 2] = op;
        req_a[4*i +: 4]  = a;
        req_b[4*i +: 4]  = b;
    endtask

    // Lone request from requester i with rsp_ready held high; called at a negedge in IDLE.
    task automatic do_req(input int i, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] exp_r, input logic exp_o);
        set_req(i, op, a, b);
        req_valid = 4'b0001 << i;
        #1;
        check("accept_ready", req_ready, 32'(4'b0001 << i));
        check("accept_busy", busy, 0);
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        check("exec_ready", req_ready, 0);
        check("exec_busy", busy, 1);
        check("exec_valid", rsp_valid, 0);
        @(negedge clk);
        #1;
        check("rsp_valid", rsp_valid, 1);
        check("rsp_result", rsp_result, exp_r);
        check("rsp_overflow", rsp_overflow, exp_o);
        check("rsp_id", rsp_id, i);
        $display("txn req=%0d op=%0d a=%h b=%h result=%h ovf=%0d id=%0d",
                 i, op, a, b, rsp_result, rsp_overflow, rsp_id);
        @(negedge clk);
        #1;
        check("idle_valid", rsp_valid, 0);
        check("idle_busy", busy, 0);
        check("idle_result_hold", rsp_result, exp_r);
    endtask

    initial begin
        int cnt;
        int expg;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
`ifdef ALU4_SCHED_STICKY_OVF_EN
        ovf_clr   = '0;
`endif
        @(negedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_rsp_overflow", rsp_overflow, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_req(0, 2'd0, 4'b0100, 4'b0011, 4'b0111, 1'b0);
        do_req(1, 2'd1, 4'b1010, 4'b0100, 4'b0110, 1'b0);
        do_req(2, 2'd2, 4'b1010, 4'b1100, 4'b1000, 1'b0);
        do_req(3, 2'd3, 4'b1010, 4'b1100, 4'b1110, 1'b0);
        do_req(0, 2'd0, 4'b1111, 4'b0001, 4'b0000, 1'b1);
        do_req(1, 2'd1, 4'b0000, 4'b0001, 4'b1111, 1'b1);

        // Round-robin with all requesters valid from reset: req i computes i+1.
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 2'd0, 4'(i), 4'd1);
        req_valid = 4'b1111;
        #1;
        for (int g = 0; g < 5; g++) begin
            expg = g % 4;
            cnt  = 0;
            while (req_ready == 4'b0000 && cnt < 10) begin
                @(negedge clk);
                #1;
                cnt++;
            end
            check("rr_grant", req_ready, 32'(4'b0001 << expg));
            @(negedge clk);
            #1;
            check("rr_pulse", req_ready, 0);
            @(negedge clk);
            #1;
            check("rr_rsp_id", rsp_id, expg);
            check("rr_rsp_result", rsp_result, expg + 1);
            $display("txn rr grant=%0d id=%0d result=%h", expg, rsp_id, rsp_result);
        end
        req_valid = 4'b0000;
        @(negedge clk);

        // Backpressure: pointer is 1; req1 wins over req2, req2 waits through RESP.
        rsp_ready = 1'b0;
        set_req(1, 2'd0, 4'd9, 4'd9);
        set_req(2, 2'd1, 4'd3, 4'd5);
        req_valid = 4'b0110;
        #1;
        check("bp_grant1", req_ready, 32'h2);
        @(negedge clk);
        req_valid = 4'b0100;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_valid", rsp_valid, 1);
            check("bp_result", rsp_result, 4'd2);
            check("bp_overflow", rsp_overflow, 1);
            check("bp_id", rsp_id, 1);
            check("bp_ready", req_ready, 0);
            check("bp_busy", busy, 1);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", req_ready, 0);
        $display("txn bp req=1 result=%h ovf=%0d id=%0d", rsp_result, rsp_overflow, rsp_id);
        @(negedge clk);
        #1;
        check("bp_grant2", req_ready, 32'h4);
        check("bp_valid_drop", rsp_valid, 0);
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        #1;
        check("bp2_result", rsp_result, 4'd14);
        check("bp2_overflow", rsp_overflow, 1);
        check("bp2_id", rsp_id, 2);
        $display("txn bp req=2 result=%h ovf=%0d id=%0d", rsp_result, rsp_overflow, rsp_id);
        @(negedge clk);

        // Async reset in EXEC: pointer is 3, requester 2 granted, then aborted.
        set_req(2, 2'd0, 4'd1, 4'd1);
        req_valid = 4'b0100;
        #1;
        check("ar_grant", req_ready, 32'h4);
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        check("ar_exec_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("ar_valid", rsp_valid, 0);
        check("ar_busy", busy, 0);
        check("ar_ready", req_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            if (rsp_valid) cnt++;
        end
        check("ar_no_replay", cnt, 0);
        set_req(1, 2'd3, 4'b0101, 4'b0010);
        set_req(3, 2'd2, 4'b1111, 4'b0011);
        req_valid = 4'b1010;
        #1;
        check("ar_ptr_zero", req_ready, 32'h2);
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        #1;
        check("ar_post_id", rsp_id, 1);
        check("ar_post_result", rsp_result, 4'b0111);
        $display("txn post-reset req=1 result=%h id=%0d", rsp_result, rsp_id);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
